// File: rtl/sort_engine_dispatcher_pkg.sv
// Shared types and the cyclic first-one search used by the dispatcher's round-robin grant.
package sort_engine_pkg;

    typedef enum logic {
        DISP_IDLE,
        DISP_SEND
    } disp_state_t;

    localparam int MAX_ENGINES = 32;

    // First set bit of req[0 +: n], searching upward from last+1 and wrapping; 0 if none.
    function automatic int rr_first(input logic [MAX_ENGINES-1:0] req, input int last, input int n);
        int   r;
        int   idx;
        logic found;
        r     = 0;
        found = 1'b0;
        for (int i = 1; i <= MAX_ENGINES; i++) begin
            if (i <= n) begin
                idx = (last + i) % n;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    r     = idx;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sort_engine_dispatcher_if.sv
// Packet input, engine-bank and order-publication signals of the sort engine dispatcher.
interface sort_engine_dispatcher_if #(
    parameter int DWIDTH     = 32,
    parameter int ENGINE_CNT = 4,
    parameter int IDW        = $clog2(ENGINE_CNT)
);
    logic [DWIDTH-1:0]     data_i;
    logic                  sop_i;
    logic                  eop_i;
    logic                  val_i;
    logic                  ready_o;
    logic [DWIDTH-1:0]     eng_data_o;
    logic [ENGINE_CNT-1:0] eng_sop_o;
    logic [ENGINE_CNT-1:0] eng_eop_o;
    logic [ENGINE_CNT-1:0] eng_val_o;
    logic [ENGINE_CNT-1:0] eng_ready_i;
    logic [ENGINE_CNT-1:0] eng_done_i;
    logic [IDW-1:0]        ord_id_o;
    logic                  ord_val_o;
    logic                  ord_ready_i;
    logic [ENGINE_CNT-1:0] busy_o;

    modport master (
        output data_i, sop_i, eop_i, val_i, eng_ready_i, eng_done_i, ord_ready_i,
        input  ready_o, eng_data_o, eng_sop_o, eng_eop_o, eng_val_o, ord_id_o, ord_val_o, busy_o
    );

    modport slave (
        input  data_i, sop_i, eop_i, val_i, eng_ready_i, eng_done_i, ord_ready_i,
        output ready_o, eng_data_o, eng_sop_o, eng_eop_o, eng_val_o, ord_id_o, ord_val_o, busy_o
    );
endinterface

// File: rtl/sort_engine_dispatcher_arb.sv
// Round-robin pick of a free engine starting after the last grant.
// Purely combinational; no backpressure of its own.
module rr_arbiter
    import sort_engine_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] grant,
    output logic           any
);
    logic [MAX_ENGINES-1:0] req_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        grant          = IDW'(rr_first(req_ext, int'(last), N));
        any            = |req;
    end
endmodule

// File: rtl/sort_engine_dispatcher.sv
// Grants each input packet to a free sort engine round-robin and records the dispatch order.
// Zero-latency forward path; ready_o follows the selected engine in a packet, free engine + order space at sop.
module sort_engine_dispatcher
    import sort_engine_pkg::*;
#(
    parameter int AWIDTH     = 10,
    parameter int DWIDTH     = 32,
    parameter int ENGINE_CNT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    sort_engine_dispatcher_if.slave  bus
);
    localparam int IDW   = $clog2(ENGINE_CNT);
    localparam int DEPTH = 2 * ENGINE_CNT;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    if (ENGINE_CNT < 2 || AWIDTH < 1 || DWIDTH < 1) begin : g_param_check
        $error("sort_engine_dispatcher: illegal parameterisation");
    end

    disp_state_t           state_q, state_d;
    logic [ENGINE_CNT-1:0] busy_q;
    logic [IDW-1:0]        last_q, sel_q, grant;
    logic                  any_free, can_start, start, full, pop;
    logic [IDW-1:0]        ord_mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;

    rr_arbiter #(.N(ENGINE_CNT), .IDW(IDW)) u_arb (
        .req   (~busy_q),
        .last  (last_q),
        .grant (grant),
        .any   (any_free)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full          = (cnt == CW'(DEPTH));
    assign can_start     = any_free & ~full;
    assign pop           = (cnt != '0) & bus.ord_ready_i;
    assign bus.ord_val_o = (cnt != '0);
    assign bus.ord_id_o  = bus.ord_val_o ? ord_mem[rd_ptr] : '0;
    assign bus.busy_o    = busy_q;

    always_comb begin
        state_d        = state_q;
        start          = 1'b0;
        bus.ready_o    = 1'b1;
        bus.eng_data_o = bus.data_i;
        bus.eng_val_o  = '0;
        bus.eng_sop_o  = '0;
        bus.eng_eop_o  = '0;
        case (state_q)
            DISP_IDLE: begin
                // Non-sop words here are stragglers of a dropped packet: accept and discard.
                bus.ready_o = bus.sop_i ? can_start : 1'b1;
                if (bus.val_i && bus.sop_i && can_start) begin
                    start                = 1'b1;
                    bus.eng_val_o[grant] = 1'b1;
                    bus.eng_sop_o[grant] = 1'b1;
                    bus.eng_eop_o[grant] = bus.eop_i;
                    if (!bus.eop_i) state_d = DISP_SEND;
                end
            end
            DISP_SEND: begin
                bus.ready_o          = bus.eng_ready_i[sel_q];
                bus.eng_val_o[sel_q] = bus.val_i;
                bus.eng_eop_o[sel_q] = bus.val_i & bus.eop_i;
                if (bus.val_i && bus.eng_ready_i[sel_q] && bus.eop_i) state_d = DISP_IDLE;
            end
            default: state_d = DISP_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DISP_IDLE;
            busy_q  <= '0;
            last_q  <= IDW'(ENGINE_CNT - 1);
            sel_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (busy_q & ~bus.eng_done_i) | (start ? (ENGINE_CNT'(1) << grant) : '0);
            if (start) begin
                sel_q  <= grant;
                last_q <= grant;
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({start, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (start) ord_mem[wr_ptr] <= grant;
    end
endmodule
